// File: rtl/led_frame_sequencer.sv
// Frame-index generator for the LED animation pattern decoders: divides clk down to the
// frame rate and steps a 5-bit index 0..LAST_FRAME with one-shot/loop, pause, stop, restart.
module led_frame_sequencer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int FRAME_HZ   = 10,
    parameter int LAST_FRAME = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       pause_i,
    input  logic       loop_en_i,
    output logic [4:0] frame_o,
    output logic       tick_o,
    output logic       running_o,
    output logic       done_o
);

    localparam int DIV = CLK_HZ / FRAME_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [4:0]    LAST      = 5'(LAST_FRAME);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [PW-1:0]   presc_r, presc_s;
    logic [4:0]      frame_r, frame_s;
    logic            tick_r, tick_s;
    logic            done_r, done_s;
    logic            running_r, running_s;

    // Next-state and next-output logic; stop beats start beats pause.
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        frame_s = frame_r;
        tick_s  = 1'b0;
        done_s  = 1'b0;
        if (stop_i) begin
            state_s = IDLE;
            presc_s = '0;
            frame_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        state_s = RUN;
                        presc_s = '0;
                        frame_s = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    if (start_i) begin
                        presc_s = '0;
                        frame_s = '0;
                    end else if (pause_i) begin
                        state_s = PAUSED;
                    end else if (presc_r == PRESC_MAX) begin
                        presc_s = '0;
                        tick_s  = 1'b1;
                        // Any index at or beyond LAST wraps, so frame_o can never exceed it.
                        if (frame_r < LAST) begin
                            frame_s = frame_r + 5'd1;
                        end else begin
                            frame_s = '0;
                            if (loop_en_i) begin
                                state_s = RUN;
                            end else begin
                                state_s = IDLE;
                                done_s  = 1'b1;
                            end
                        end
                    end else begin
                        presc_s = presc_r + PW'(1);
                    end
                end
                PAUSED: begin
                    if (start_i || pause_i) begin
                        state_s = RUN;
                    end else begin
                        state_s = PAUSED;
                    end
                end
                default: begin
                    state_s = IDLE;
                    presc_s = '0;
                    frame_s = '0;
                end
            endcase
        end
        running_s = (state_s != IDLE);
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            presc_r   <= '0;
            frame_r   <= '0;
            tick_r    <= 1'b0;
            done_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            frame_r   <= frame_s;
            tick_r    <= tick_s;
            done_r    <= done_s;
            running_r <= running_s;
        end
    end

    assign frame_o   = frame_r;
    assign tick_o    = tick_r;
    assign running_o = running_r;
    assign done_o    = done_r;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer: DIV=10/LAST_FRAME=16 main instance plus a
// DIV=1/LAST_FRAME=0 instance for the degenerate-divider corner.
module tb_led_frame_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_s, stop_s, pause_s, loop_s;
    logic [4:0] frame_s;
    logic       tick_s, running_s, done_s;

    logic       b_start_s, b_loop_s, b_zero_s;
    logic [4:0] b_frame_s;
    logic       b_tick_s, b_running_s, b_done_s;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int cyc;
        int frame;
        int tick;
        int run;
        int done;
    } vec_t;

    led_frame_sequencer #(.CLK_HZ(100), .FRAME_HZ(10), .LAST_FRAME(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_s), .stop_i(stop_s), .pause_i(pause_s),
        .loop_en_i(loop_s), .frame_o(frame_s), .tick_o(tick_s), .running_o(running_s),
        .done_o(done_s)
    );

    led_frame_sequencer #(.CLK_HZ(10), .FRAME_HZ(10), .LAST_FRAME(0)) u_div1 (
        .clk(clk), .rst_n(rst_n), .start_i(b_start_s), .stop_i(b_zero_s), .pause_i(b_zero_s),
        .loop_en_i(b_loop_s), .frame_o(b_frame_s), .tick_o(b_tick_s), .running_o(b_running_s),
        .done_o(b_done_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit st, input bit sp, input bit pa);
        start_s = st; stop_s = sp; pause_s = pa;
        step();
        start_s = 1'b0; stop_s = 1'b0; pause_s = 1'b0;
    endtask

    // Steps n cycles and returns how many of them showed tick_o / done_o high.
    task automatic run_n(input int n, output int ticks, output int dones);
        ticks = 0; dones = 0;
        for (int i = 0; i < n; i++) begin
            step();
            ticks += int'(tick_s);
            dones += int'(done_s);
        end
    endtask

    vec_t vec[11];
    int   t, d, bad, k;

    initial begin
        vec[0]  = '{0,   0,  0, 1, 0};
        vec[1]  = '{9,   0,  0, 1, 0};
        vec[2]  = '{10,  1,  1, 1, 0};
        vec[3]  = '{11,  1,  0, 1, 0};
        vec[4]  = '{20,  2,  1, 1, 0};
        vec[5]  = '{100, 10, 1, 1, 0};
        vec[6]  = '{160, 16, 1, 1, 0};
        vec[7]  = '{169, 16, 0, 1, 0};
        vec[8]  = '{170, 0,  1, 0, 1};
        vec[9]  = '{171, 0,  0, 0, 0};
        vec[10] = '{172, 0,  0, 0, 0};

        rst_n = 1'b0;
        start_s = 1'b0; stop_s = 1'b0; pause_s = 1'b0; loop_s = 1'b0;
        b_start_s = 1'b0; b_loop_s = 1'b0; b_zero_s = 1'b0;
        #2;
        chk("reset_frame", int'(frame_s), 0);
        chk("reset_running", int'(running_s), 0);
        chk("reset_tick_done", int'(tick_s) + int'(done_s), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: nothing moves, and a stray pause is ignored.
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            pause_s = (i == 20);
            step();
            bad += int'(tick_s) + int'(done_s) + int'(running_s) + int'(frame_s != 5'd0);
        end
        pause_s = 1'b0;
        chk("idle_quiet", bad, 0);

        // One-shot playback against the checkpoint table.
        loop_s = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        k = 0;
        for (int c = 0; c <= 172; c++) begin
            if (c > 0) step();
            while (k < 11 && vec[k].cyc == c) begin
                chk($sformatf("oneshot[%0d].frame", c), int'(frame_s), vec[k].frame);
                chk($sformatf("oneshot[%0d].tick", c), int'(tick_s), vec[k].tick);
                chk($sformatf("oneshot[%0d].running", c), int'(running_s), vec[k].run);
                chk($sformatf("oneshot[%0d].done", c), int'(done_s), vec[k].done);
                k++;
            end
        end

        // Looping: wrap at 170 without done, frame 1 at 180.
        loop_s = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        run_n(170, t, d);
        chk("loop_ticks_to_170", t, 17);
        chk("loop_wrap_frame", int'(frame_s), 0);
        chk("loop_wrap_running", int'(running_s), 1);
        chk("loop_no_done", d, 0);
        run_n(10, t, d);
        chk("loop_frame_180", int'(frame_s), 1);
        chk("loop_tick_180", int'(tick_s), 1);
        loop_s = 1'b0;
        pulse(1'b0, 1'b1, 1'b0);
        chk("stop_running", int'(running_s), 0);

        // Pause at frame 5 / prescaler 3.
        pulse(1'b1, 1'b0, 1'b0);
        run_n(53, t, d);
        pulse(1'b0, 1'b0, 1'b1);
        chk("pause_frame", int'(frame_s), 5);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            bad += int'(tick_s) + int'(frame_s != 5'd5) + int'(!running_s);
        end
        chk("pause_hold", bad, 0);
        pulse(1'b0, 1'b0, 1'b1);
        run_n(6, t, d);
        chk("resume_no_early_tick", t, 0);
        step();
        chk("resume_tick", int'(tick_s), 1);
        chk("resume_frame", int'(frame_s), 6);
        // start while paused resumes rather than restarts
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("start_resume_frame", int'(frame_s), 6);
        chk("start_resume_running", int'(running_s), 1);
        run_n(9, t, d);
        chk("start_resume_no_tick", t, 0);
        step();
        chk("start_resume_tick_frame", int'(tick_s) * 100 + int'(frame_s), 107);

        // stop+start together, then restart mid-sequence.
        pulse(1'b1, 1'b0, 1'b0);
        run_n(35, t, d);
        pulse(1'b1, 1'b1, 1'b0);
        chk("stopstart_running", int'(running_s), 0);
        chk("stopstart_frame", int'(frame_s), 0);
        chk("stopstart_done", int'(done_s), 0);
        pulse(1'b1, 1'b0, 1'b0);
        run_n(95, t, d);
        chk("restart_pre_frame", int'(frame_s), 9);
        pulse(1'b1, 1'b0, 1'b0);
        chk("restart_frame", int'(frame_s), 0);
        chk("restart_running", int'(running_s), 1);
        run_n(9, t, d);
        chk("restart_no_tick_done", t + d, 0);
        step();
        chk("restart_tick_frame", int'(tick_s) * 100 + int'(frame_s), 101);
        pulse(1'b0, 1'b1, 1'b0);

        // Asynchronous reset between edges.
        pulse(1'b1, 1'b0, 1'b0);
        run_n(75, t, d);
        chk("prereset_frame", int'(frame_s), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_frame", int'(frame_s), 0);
        chk("async_reset_running", int'(running_s), 0);
        chk("async_reset_tick_done", int'(tick_s) + int'(done_s), 0);
        #3 rst_n = 1'b1;
        run_n(20, t, d);
        chk("post_reset_idle", t + d + int'(running_s) + int'(frame_s), 0);

        // DIV=1, LAST_FRAME=0: one-shot finishes on the first edge, loop ticks every cycle.
        b_loop_s = 1'b0;
        b_start_s = 1'b1; step(); b_start_s = 1'b0;
        chk("div1_start_running", int'(b_running_s) * 10 + int'(b_tick_s), 10);
        step();
        chk("div1_done", int'(b_done_s) * 100 + int'(b_tick_s) * 10 + int'(b_running_s), 110);
        b_loop_s = 1'b1;
        b_start_s = 1'b1; step(); b_start_s = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            bad += int'(!b_tick_s) + int'(b_done_s) + int'(!b_running_s) + int'(b_frame_s != 5'd0);
        end
        chk("div1_loop_every_cycle", bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
